// File: rtl/pipe_share_pkg.sv
// Shared types and helpers for the pipe_share_arbiter slice.
package pipe_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

  // Minimum result of 1 so a 1-wide index is still legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipe_share_if.sv
// Requester/consumer bundle for pipe_share_arbiter; slave modport is the arbiter side.
interface pipe_share_if
  import pipe_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 1
) ();

  localparam int unsigned ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic                      hold;
  logic [NUM_REQ-1:0]        gnt;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;

  modport master (
    output req, req_data, req_lock, hold,
    input  gnt, out_valid, out_data, out_id
  );

  modport slave (
    input  req, req_data, req_lock, hold,
    output gnt, out_valid, out_data, out_id
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority picker: first active req after ptr, wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin share of a DEPTH-stage capture pipeline among NUM_REQ requesters.
// Optional burst locking is enabled by defining ARB_LOCK_EN.
module pipe_share_arbiter
  import pipe_share_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst_n,
  pipe_share_if.slave bus
);

  localparam int unsigned ID_W = clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     win;
  logic                lock_keep;
  logic                xfer;
  logic [DATA_W-1:0]   win_data;

  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [ID_W-1:0]     id_q  [DEPTH];
  logic [ID_W-1:0]     id_d  [DEPTH];
  logic [DATA_W-1:0]   dat_q [DEPTH];
  logic [DATA_W-1:0]   dat_d [DEPTH];

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef ARB_LOCK_EN
  localparam int unsigned BCNT_W = clog2(MAX_BURST);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  // While locked, ptr_q holds the lock owner.
  assign lock_keep = (state_q == ST_LOCK) && bus.req[ptr_q] && bus.req_lock[ptr_q];
`else
  logic unused_lock;

  assign lock_keep   = 1'b0;
  assign unused_lock = ^bus.req_lock ^ (MAX_BURST == 0);
`endif

  always_comb begin
    win      = lock_keep ? ptr_q : pick_idx;
    gnt      = '0;
    if (!bus.hold) gnt = lock_keep ? (NUM_REQ'(1) << ptr_q) : pick_gnt;
    xfer     = |gnt;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.gnt = gnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
    bcnt_d  = bcnt_q;
`endif
    if (!bus.hold) begin
      if (xfer) begin
        ptr_d   = win;
        state_d = ST_ARB;
`ifdef ARB_LOCK_EN
        bcnt_d  = '0;
        // bcnt counts grants already made in the burst; the MAX_BURST-th one releases.
        if (lock_keep) begin
          if (bcnt_q != BCNT_W'(MAX_BURST - 1)) begin
            state_d = ST_LOCK;
            bcnt_d  = bcnt_q + 1'b1;
          end
        end else if (bus.req_lock[win] && (MAX_BURST > 1)) begin
          state_d = ST_LOCK;
          bcnt_d  = BCNT_W'(1);
        end
`endif
      end else begin
        state_d = ST_IDLE;
`ifdef ARB_LOCK_EN
        bcnt_d  = '0;
`endif
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    dat_d = dat_q;
    if (!bus.hold) begin
      vld_d[0] = xfer;
      id_d[0]  = xfer ? win : '0;
      dat_d[0] = win_data;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
        dat_d[s] = dat_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      vld_q   <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        id_q[s]  <= '0;
        dat_q[s] <= '0;
      end
`ifdef ARB_LOCK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      dat_q   <= dat_d;
`ifdef ARB_LOCK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign bus.out_valid = vld_q[DEPTH-1];
  assign bus.out_id    = id_q[DEPTH-1];
  assign bus.out_data  = dat_q[DEPTH-1];

endmodule
